// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between display reads
// (always win) and a one-entry buffered host write path.
module vga_fb_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_disp_req,
   input  logic              i_disp_frame_start,
   output logic              o_disp_valid,
   output logic [DATA_W-1:0] o_disp_data,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_err,
   output logic              o_ram_en,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);
   localparam logic [ADDR_W:0]   NPIX = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic {EMPTY, FULL} buf_e;
   buf_e              buf_q, buf_d;
   logic [ADDR_W-1:0] da_q, da_d, baddr_q, baddr_d;
   logic [DATA_W-1:0] bdata_q, bdata_d, ddata_q, ddata_d;
   logic              rdy_q, err_q, p1_q, dvalid_q;
   logic              accept, in_range, wr_go;

   assign accept   = i_wr_valid & rdy_q;
   assign in_range = {1'b0, i_wr_addr} < NPIX;
   assign wr_go    = (buf_q == FULL) & ~i_disp_req;

   always_ff @(posedge i_clk)
      buf_q <= !i_rst_n ? EMPTY : buf_d;

   always_comb
      buf_d = (buf_q == EMPTY && accept && in_range) ? FULL : wr_go ? EMPTY : buf_q;

   // RAM port is gated by reset so a buffered write can never land during it
   always_comb begin
      o_ram_en    = i_rst_n & (i_disp_req | (buf_q == FULL));
      o_ram_we    = i_rst_n & wr_go;
      o_ram_addr  = i_disp_req ? da_q : baddr_q;
      o_ram_wdata = bdata_q;
   end

   always_comb begin
      baddr_d = accept ? i_wr_addr : baddr_q;
      bdata_d = accept ? i_wr_data : bdata_q;
      da_d    = i_disp_frame_start ? '0 : !i_disp_req ? da_q : da_q == LAST ? '0 : da_q + 1'b1;
      ddata_d = p1_q ? i_ram_rdata : ddata_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         da_q     <= '0;
         baddr_q  <= '0;
         bdata_q  <= '0;
         rdy_q    <= 1'b0;
         err_q    <= 1'b0;
         p1_q     <= 1'b0;
         dvalid_q <= 1'b0;
         ddata_q  <= '0;
      end else begin
         da_q     <= da_d;
         baddr_q  <= baddr_d;
         bdata_q  <= bdata_d;
         rdy_q    <= buf_d == EMPTY;
         err_q    <= err_q | (accept & ~in_range);
         p1_q     <= i_disp_req;
         dvalid_q <= p1_q;
         ddata_q  <= ddata_d;
      end
   end

   assign o_wr_ready   = rdy_q;
   assign o_wr_err     = err_q;
   assign o_disp_valid = dvalid_q;
   assign o_disp_data  = ddata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the framebuffer, write buffer and display fetch.
module tb_vga_fb_arbiter;
   localparam int H = 8;
   localparam int V = 4;
   localparam int AW = 6;
   localparam int DW = 3;
   localparam int NPIX = H * V;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          disp_req = 1'b0, frame_start = 1'b0, wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          disp_valid, wr_ready, wr_err, ram_en, ram_we;
   logic [DW-1:0] disp_data, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] golden [2**AW];

   int n_tests = 0, n_fail = 0;
   int m_da;
   bit m_pend, m_err, m_rdy, s1v, s2v;
   int m_paddr;
   logic [DW-1:0] m_pdata, s1d, s2d, m_last;

   vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_disp_req(disp_req), .i_disp_frame_start(frame_start),
      .o_disp_valid(disp_valid), .o_disp_data(disp_data), .i_wr_valid(wr_valid),
      .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_err(wr_err),
      .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit rn, input bit req, input bit fs, input bit wv,
                       input int wa, input logic [DW-1:0] wd);
      bit exp_en;
      rst_n = rn;
      disp_req = req;
      frame_start = fs;
      wr_valid = wv;
      wr_addr = AW'(wa);
      wr_data = wd;
      @(negedge clk);
      if (!rn) begin
         chk("ram_en_in_reset", 32'(ram_en), 0);
         m_da = 0; m_pend = 0; m_err = 0; m_rdy = 0;
         s1v = 0; s2v = 0; m_last = '0;
      end else begin
         exp_en = req | m_pend;
         chk("ram_en", 32'(ram_en), 32'(exp_en));
         if (exp_en) begin
            chk("ram_we", 32'(ram_we), 32'(!req));
            chk("ram_addr", 32'(ram_addr), req ? m_da : m_paddr);
            if (!req) chk("ram_wdata", 32'(ram_wdata), 32'(m_pdata));
         end
         chk("wr_ready", 32'(wr_ready), 32'(m_rdy));
         chk("wr_err", 32'(wr_err), 32'(m_err));
         chk("disp_valid", 32'(disp_valid), 32'(s2v));
         chk("disp_data", 32'(disp_data), 32'(s2v ? s2d : m_last));
         if (s2v) m_last = s2d;
         s2v = s1v;
         s2d = s1d;
         s1v = req;
         s1d = golden[m_da];
         if (!req && m_pend) begin
            golden[m_paddr] = m_pdata;
            m_pend = 0;
         end else if (wv && m_rdy) begin
            if (wa < NPIX) begin
               m_pend = 1;
               m_paddr = wa;
               m_pdata = wd;
            end else m_err = 1;
         end
         if (fs) m_da = 0;
         else if (req) m_da = (m_da + 1) % NPIX;
         m_rdy = !m_pend;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      repeat (3) step(0, 1, 0, 0, 0, 0);
      for (int a = 0; a < NPIX; a++) begin
         step(1, 0, 0, 1, a, DW'($urandom));
         step(1, 0, 0, 0, 0, 0);
      end
      repeat (2) step(0, 0, 0, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 5, 3'b101);
      repeat (2) step(1, 0, 0, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 9, 3'b010);
      repeat (10) step(1, 1, 0, 1, 11, 3'b111);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      repeat (NPIX + 5) step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, NPIX, 3'b110);
      repeat (4) step(1, 0, 0, 1, 60, 3'b001);
      step(0, 0, 0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 7, 3'b110);
      step(1, 1, 0, 0, 0, 0);
      repeat (2) step(0, 1, 0, 1, 3, 3'b001);
      repeat (4) step(1, 0, 0, 0, 0, 0);
      repeat (3000)
         step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
              1'($urandom), int'($urandom_range(0, 2 * NPIX - 1 - NPIX / 2)), DW'($urandom));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter ADDR_W, default 19, framebuffer address width; SHALL satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
REQ-004 Parameter DATA_W, default 3, pixel width, {R,G,B} MSB first.
REQ-005 i_clk  in  1  single clock for all logic.
REQ-006 i_rst_n  in  1  reset; synchronous, active-low.
REQ-007 i_disp_req  in  1  single-cycle request from the timing generator for the next active pixel.
REQ-008 i_disp_frame_start  in  1  single-cycle pulse that restarts display fetch at address 0.
REQ-009 o_disp_valid  out  1  o_disp_data holds the requested pixel.
REQ-010 o_disp_data  out  DATA_W  fetched pixel.
REQ-011 i_wr_valid  in  1  host write request.
REQ-012 o_wr_ready  out  1  host write accepted when high with i_wr_valid.
REQ-013 i_wr_addr  in  ADDR_W  host write address.
REQ-014 i_wr_data  in  DATA_W  host write pixel.
REQ-015 o_wr_err  out  1  sticky flag: an out-of-range host write was dropped.
REQ-016 o_ram_en, o_ram_we  out  1 each  single-port RAM enable and write enable.
REQ-017 o_ram_addr  out  ADDR_W;  o_ram_wdata  out  DATA_W  RAM address and write data.
REQ-018 i_ram_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after a read enable.

Function
REQ-019 The block SHALL contain a display address counter DA, a one-entry host write buffer (state EMPTY/FULL) and a 2-stage display pipeline.
REQ-020 Priority: in any cycle with i_disp_req=1, the RAM port SHALL perform a display read at DA (o_ram_en=1, o_ram_we=0, o_ram_addr=DA).
REQ-021 In a cycle with i_disp_req=0 and buffer FULL, the RAM port SHALL write the buffered entry (o_ram_en=1, o_ram_we=1); the buffer goes EMPTY at the next edge.
REQ-022 Otherwise o_ram_en=0, o_ram_we=0.
REQ-023 o_ram_* SHALL be combinational from the registered DA, registered buffer and i_disp_req.
REQ-024 o_wr_ready SHALL be registered and equal (buffer EMPTY).
REQ-025 On handshake (i_wr_valid & o_wr_ready), the address and data SHALL be captured and the buffer goes FULL if i_wr_addr < H_ACTIVE*V_ACTIVE.
REQ-026 If the address is out of range, the buffer SHALL stay EMPTY and o_wr_err SHALL set at the next edge.
REQ-027 o_wr_err SHALL clear only on reset.
REQ-028 Buffer FULL to EMPTY and a new accept SHALL NOT occur in the same cycle, because ready is low while FULL; host throughput is at most one write per 2 cycles.
REQ-029 DA SHALL increment after each display read.
REQ-030 DA SHALL wrap from H_ACTIVE*V_ACTIVE-1 to 0.
REQ-031 i_disp_frame_start SHALL load DA=0 at the next edge and take precedence over an increment in the same cycle.
REQ-032 A read issued in that same cycle SHALL use the old DA.
REQ-033 Display latency: a read issued in cycle N gives o_disp_valid=1 and o_disp_data=i_ram_rdata (registered) in cycle N+2 only; o_disp_valid is a single-cycle pulse per request.
REQ-034 o_disp_data SHALL hold its last value while o_disp_valid=0.
REQ-035 Back-to-back requests SHALL give back-to-back valids with no bubbles.
REQ-036 Under continuous i_disp_req a FULL buffer SHALL wait indefinitely; the display is never stalled.

Reset
REQ-037 While i_rst_n=0 at a rising edge, the block SHALL clear DA=0, buffer EMPTY, both pipeline stages invalid, o_disp_valid=0, o_disp_data=0 and o_wr_err=0.
REQ-038 o_wr_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-039 A reset mid-operation SHALL discard a buffered write and any in-flight reads without a RAM write.
REQ-040 o_ram_en SHALL be 0 in every cycle with i_rst_n=0.

Verification
REQ-041 Reset then 3 consecutive i_disp_req -> o_ram_addr 0,1,2 in cycles 0-2; o_disp_valid high in cycles 2-4 carrying the RAM contents of 0,1,2.
REQ-042 Host write addr=5 data=3'b101 with i_disp_req=0 -> ready drops for 1 cycle; RAM write at addr 5 one cycle after accept; a later display read of 5 returns 3'b101.
REQ-043 Write buffered while i_disp_req held high for 10 cycles -> no RAM write during those 10 cycles; write issued in the first cycle i_disp_req=0; o_wr_ready=0 throughout.
REQ-044 Issue 307200 requests at H/V defaults -> the last read uses addr 307199; the next uses addr 0; i_disp_frame_start with a concurrent request at DA=100 -> read addr 100, next read addr 0.
REQ-045 Host write addr=307200 -> no RAM write, o_wr_err=1 next cycle and it stays set; o_wr_ready stays 1.
REQ-046 Reset asserted with buffer FULL and 2 reads in flight -> no RAM write; no o_disp_valid after reset; o_wr_ready=1 one cycle after release.
